univ_counter: RTL and testbench

Parametrised universal counter with a built-in prescaler. It generalises the fixed 4-bit up-counter to any width, with up, down, load and hold modes, a programmable modulus and a terminal-count pulse. The prescaler replaces the hard-wired 23-bit clock divider with a parameter, so the same block drives board LEDs (slow tick) and runs cycle-accurate in simulation (`DIV_BITS=0`). It is the common counting element for lab top-levels and for later timer/PWM blocks.

---
 rtl/univ_counter.sv | 124 ++++++++++++
 tb/tb_univ_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_counter.sv
// univ_counter: parametrised up/down/load/hold counter with a programmable
// modulus, a terminal-count pulse and a built-in power-of-two prescaler.
// The prescaler produces a registered one-cycle tick. The counter consumes
// that registered tick one cycle later as its step enable.
module univ_counter #(
    parameter int WIDTH    = 8,
    parameter int DIV_BITS = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             tick
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic             tick_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] top;
    logic             step_up;
    logic             step_down;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    generate
        if (DIV_BITS == 0) begin : g_nodiv
            // Without a divider every edge after reset is a tick.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= 1'b1;
                end
            end
        end else begin : g_div
            logic [DIV_BITS-1:0] pre_q, pre_d;

            assign pre_d = pre_q + DIV_BITS'(1);

            // Free-running divider; tick marks the edge where it wraps to 0.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pre_q  <= '0;
                    tick_q <= 1'b0;
                end else begin
                    pre_q  <= pre_d;
                    tick_q <= &pre_q;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------

    // A zero modulus selects the full binary range.
    always_comb begin
        top = '1;
        if (modulus != '0) begin
            top = modulus - WIDTH'(1);
        end
    end

    // Steps need the previous cycle's tick, the enable and a counting mode.
    assign step_up   = tick_q & en & (mode == MODE_UP);
    assign step_down = tick_q & en & (mode == MODE_DOWN);

    // Next count and terminal count, priority clr > load > step > hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (mode == MODE_LOAD) begin
            // Saturate loads above the current range to top.
            count_d = (load_val > top) ? top : load_val;
        end else if (step_up) begin
            if (count_q >= top) begin
                count_d = '0;
                tc_d    = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (step_down) begin
            // Also recovers when the modulus was lowered below the count.
            if ((count_q == '0) || (count_q > top)) begin
                count_d = top;
                tc_d    = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end else if (mode == MODE_HOLD) begin
            count_d = count_q;
        end
    end

    // Count and terminal-count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_univ_counter.sv
// Bench for univ_counter: one instance without a prescaler and one with a
// 4-cycle prescaler share the same stimulus. Expected values are queued as
// each step is driven and checked after the following clock edge.
module tb_univ_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [3:0] load_val;
    logic [3:0] modulus;
    logic [3:0] count0, count2;
    logic       tc0, tc2, tick0, tick2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string    tag;
        bit       sel;
        logic [3:0] cnt;
        logic     tc;
        logic     tick;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    univ_counter #(.WIDTH(4), .DIV_BITS(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .load_val(load_val), .modulus(modulus),
        .count(count0), .tc(tc0), .tick(tick0)
    );

    univ_counter #(.WIDTH(4), .DIV_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .load_val(load_val), .modulus(modulus),
        .count(count2), .tc(tc2), .tick(tick2)
    );

    task automatic push(input string tag, input bit sel, input logic [3:0] c,
                        input logic t, input logic k);
        exp_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.cnt  = c;
        e.tc   = t;
        e.tick = k;
        sb.push_back(e);
    endtask

    task automatic check_one(input logic [3:0] ac, input logic at, input logic ak,
                             input exp_t e);
        tests = tests + 3;
        assert (ac === e.cnt) else begin
            fails++;
            $error("FAIL %s count: got %0d expected %0d", e.tag, ac, e.cnt);
        end
        assert (at === e.tc) else begin
            fails++;
            $error("FAIL %s tc: got %b expected %b", e.tag, at, e.tc);
        end
        assert (ak === e.tick) else begin
            fails++;
            $error("FAIL %s tick: got %b expected %b", e.tag, ak, e.tick);
        end
        $display("[TB] %s dut%0d count=%0d tc=%b tick=%b", e.tag, e.sel ? 2 : 0, ac, at, ak);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.sel) check_one(count2, tc2, tick2, e);
            else       check_one(count0, tc0, tick0, e);
        end
    endtask

    // Advance one edge; stimulus and sampling happen 1 time unit after it.
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic step0(input string tag, input logic [3:0] c, input logic t,
                         input logic k);
        push(tag, 1'b0, c, t, k);
        clk_step();
        drain();
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b1;
        clr      = 1'b0;
        mode     = 2'b01;
        load_val = 4'd0;
        modulus  = 4'd10;

        // Reset held with counting requested.
        clk_step();
        clk_step();
        clk_step();
        push("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        push("reset", 1'b1, 4'd0, 1'b0, 1'b0);
        drain();

        // Release: tick on the first edge, step on the second.
        rst = 1'b1;
        step0("release_e1", 4'd0, 1'b0, 1'b1);
        step0("release_e2", 4'd1, 1'b0, 1'b1);

        // Up count modulo 10, three wraps.
        for (int i = 0; i < 29; i++) begin
            logic [3:0] c;
            c = 4'((2 + i) % 10);
            step0("up_mod10", c, (c == 4'd0), 1'b1);
        end

        // Full-range down count from 0.
        modulus = 4'd0;
        clr     = 1'b1;
        step0("clr", 4'd0, 1'b0, 1'b1);
        clr  = 1'b0;
        mode = 2'b10;
        step0("down_wrap", 4'd15, 1'b1, 1'b1);
        step0("down", 4'd14, 1'b0, 1'b1);
        step0("down", 4'd13, 1'b0, 1'b1);
        step0("down", 4'd12, 1'b0, 1'b1);

        // Loads, including saturation and load with en low.
        modulus  = 4'd10;
        mode     = 2'b11;
        load_val = 4'd7;
        step0("load7", 4'd7, 1'b0, 1'b1);
        load_val = 4'd12;
        step0("load_sat", 4'd9, 1'b0, 1'b1);
        en       = 1'b0;
        load_val = 4'd3;
        step0("load_en0", 4'd3, 1'b0, 1'b1);
        mode = 2'b01;
        step0("up_en0", 4'd3, 1'b0, 1'b1);
        step0("up_en0", 4'd3, 1'b0, 1'b1);
        en   = 1'b1;
        mode = 2'b00;
        step0("hold", 4'd3, 1'b0, 1'b1);

        // Modulus lowered below the count, then stepping down.
        mode     = 2'b11;
        load_val = 4'd8;
        step0("load8", 4'd8, 1'b0, 1'b1);
        modulus = 4'd5;
        mode    = 2'b10;
        step0("mod_lowered", 4'd4, 1'b1, 1'b1);
        step0("down_mod5", 4'd3, 1'b0, 1'b1);

        // Clear beats load, and beats a step with a live tick.
        clr      = 1'b1;
        mode     = 2'b11;
        load_val = 4'd7;
        step0("clr_vs_load", 4'd0, 1'b0, 1'b1);
        mode = 2'b01;
        step0("clr_vs_step", 4'd0, 1'b0, 1'b1);
        clr = 1'b0;

        // Modulus 1: count pinned at 0, every step pulses tc.
        modulus = 4'd1;
        step0("mod1_up", 4'd0, 1'b1, 1'b1);
        step0("mod1_up", 4'd0, 1'b1, 1'b1);
        mode = 2'b10;
        step0("mod1_down", 4'd0, 1'b1, 1'b1);

        // Asynchronous reset mid-operation, checked before any edge.
        modulus  = 4'd0;
        mode     = 2'b11;
        load_val = 4'd6;
        step0("load6", 4'd6, 1'b0, 1'b1);
        rst = 1'b0;
        #2;
        push("async_rst", 1'b0, 4'd0, 1'b0, 1'b0);
        push("async_rst", 1'b1, 4'd0, 1'b0, 1'b0);
        drain();
        clk_step();

        // Prescaler: tick every 4th edge, count one edge after each tick.
        mode = 2'b01;
        en   = 1'b1;
        rst  = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            if (k == 17) en = 1'b0;
            push(k <= 16 ? "presc_up" : "presc_en0", 1'b1,
                 k <= 16 ? 4'((k - 1) / 4) : 4'd3, 1'b0, (k % 4) == 0);
            clk_step();
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
